alu_cmd_sequencer: RTL and testbench

Front-end controller that drives the 4-bit combinational ALU. It accepts tagged ALU commands (op code plus two operands) over a valid/ready interface and buffers them in a small FIFO. It issues one command at a time to the ALU operand/op-code inputs, waits a fixed settle time, captures the ALU result and returns it with its tag over a valid/ready response interface. It sits between the instruction/control path and the ALU.

---
 rtl/alu_cmd_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Generic synchronous FIFO with registered storage and an occupancy count.
// Latency: an accepted write is visible at rd_dat on the following cycle.
// Backpressure: wr_rdy low when full (no bypass on a same-cycle read); rd_vld low when empty.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_vld,
    output logic                   wr_rdy,
    input  logic [W-1:0]           wr_dat,
    output logic                   rd_vld,
    input  logic                   rd_rdy,
    output logic [W-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_fire;
    logic          rd_fire;

    assign wr_rdy  = (count < DEPTH_C);
    assign rd_vld  = (count != '0);
    assign rd_dat  = mem[rd_ptr];
    assign wr_fire = wr_vld && wr_rdy;
    assign rd_fire = rd_rdy && rd_vld;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Queues tagged ALU commands, issues them one at a time to the ALU and returns the tagged result.
// Latency: accept to rsp_valid is ALU_LAT+2 cycles when idle; an illegal op responds 2 cycles after accept.
// Backpressure: cmd_ready low while the FIFO is full; a response is held stable until rsp_ready and the queue stalls behind it.
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 1,
    parameter int TAG_W      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [3:0]                  cmd_op,
    input  logic [3:0]                  cmd_a,
    input  logic [3:0]                  cmd_b,
    input  logic [TAG_W-1:0]            cmd_tag,
    output logic [3:0]                  alu_a,
    output logic [3:0]                  alu_b,
    output logic [3:0]                  alu_op,
    input  logic [3:0]                  alu_result,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [3:0]                  rsp_result,
    output logic [TAG_W-1:0]            rsp_tag,
    output logic                        rsp_err,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    typedef struct packed {
        logic [3:0]       op;
        logic [3:0]       a;
        logic [3:0]       b;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0] LAT_C = ALU_LAT[3:0];

    state_t           state;
    logic [3:0]       wait_cnt;
    logic [TAG_W-1:0] pend_tag;
    cmd_t             push_cmd;
    cmd_t             head;
    logic             head_vld;
    logic             head_legal;
    logic             fifo_pop;

    assign push_cmd = {cmd_op, cmd_a, cmd_b, cmd_tag};

    sync_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (cmd_valid),
        .wr_rdy (cmd_ready),
        .wr_dat (push_cmd),
        .rd_vld (head_vld),
        .rd_rdy (fifo_pop),
        .rd_dat (head),
        .count  (fifo_count)
    );

    // Op codes 1100..1111 are illegal and take the error-response path around the ALU.
    assign head_legal = !(head.op[3] && head.op[2]);

    // Pop when idle, or when the held response is being consumed (back-to-back issue).
    assign fifo_pop = head_vld &&
                      ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));

    assign busy = (state != ST_IDLE);

    // Issue / settle / respond sequencing with registered ALU and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            pend_tag   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
        end else if (fifo_pop) begin
            pend_tag <= head.tag;
            if (head_legal) begin
                alu_a     <= head.a;
                alu_b     <= head.b;
                alu_op    <= head.op;
                wait_cnt  <= LAT_C;
                rsp_valid <= 1'b0;
                state     <= ST_WAIT;
            end else begin
                // ALU inputs keep the last legal command; the error response is immediate.
                rsp_result <= '0;
                rsp_err    <= 1'b1;
                rsp_tag    <= head.tag;
                rsp_valid  <= 1'b1;
                state      <= ST_RESP;
            end
        end else begin
            case (state)
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        rsp_result <= alu_result;
                        rsp_err    <= 1'b0;
                        rsp_tag    <= pend_tag;
                        rsp_valid  <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
    localparam int TAG_W = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance with ALU_LAT=1
    logic             cmd_valid1, cmd_ready1;
    logic [3:0]       cmd_op1, cmd_a1, cmd_b1;
    logic [TAG_W-1:0] cmd_tag1;
    logic [3:0]       alu_a1, alu_b1, alu_op1, alu_result1;
    logic             rsp_valid1, rsp_ready1, rsp_err1, busy1;
    logic [3:0]       rsp_result1;
    logic [TAG_W-1:0] rsp_tag1;
    logic [2:0]       fifo_count1;

    // Instance with ALU_LAT=4
    logic             cmd_valid4, cmd_ready4;
    logic [3:0]       cmd_op4, cmd_a4, cmd_b4;
    logic [TAG_W-1:0] cmd_tag4;
    logic [3:0]       alu_a4, alu_b4, alu_op4, alu_result4;
    logic             rsp_valid4, rsp_ready4, rsp_err4, busy4;
    logic [3:0]       rsp_result4;
    logic [TAG_W-1:0] rsp_tag4;
    logic [2:0]       fifo_count4;

    logic             garble4;
    logic [3:0]       garble_val4;

    int n_pass  = 0;
    int n_total = 0;

    // Stand-in for the combinational ALU
    function automatic logic [3:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'b0000: return a;
            4'b0001: return a & b;
            4'b0010: return a | b;
            4'b0011: return a ^ b;
            4'b0100: return ~a;
            4'b0101: return a << 1;
            4'b0110: return a >> 1;
            4'b0111: return b;
            4'b1000: return a + b;
            4'b1001: return a - b;
            4'b1010: return a + 4'd1;
            4'b1011: return a - 4'd1;
            default: return 4'b0000;
        endcase
    endfunction

    assign alu_result1 = alu_f(alu_op1, alu_a1, alu_b1);
    assign alu_result4 = garble4 ? garble_val4 : alu_f(alu_op4, alu_a4, alu_b4);

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .ALU_LAT(1), .TAG_W(TAG_W)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_op(cmd_op1), .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_tag(cmd_tag1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_result(alu_result1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_result(rsp_result1), .rsp_tag(rsp_tag1), .rsp_err(rsp_err1),
        .busy(busy1), .fifo_count(fifo_count1)
    );

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .ALU_LAT(4), .TAG_W(TAG_W)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_op(cmd_op4), .cmd_a(cmd_a4), .cmd_b(cmd_b4), .cmd_tag(cmd_tag4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4), .alu_result(alu_result4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_result(rsp_result4), .rsp_tag(rsp_tag4), .rsp_err(rsp_err4),
        .busy(busy4), .fifo_count(fifo_count4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic [TAG_W-1:0] tag);
        cmd_valid1 = 1'b1; cmd_op1 = op; cmd_a1 = a; cmd_b1 = b; cmd_tag1 = tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid1 = 0; cmd_op1 = 0; cmd_a1 = 0; cmd_b1 = 0; cmd_tag1 = 0; rsp_ready1 = 0;
        cmd_valid4 = 0; cmd_op4 = 0; cmd_a4 = 0; cmd_b4 = 0; cmd_tag4 = 0; rsp_ready4 = 0;
        garble4 = 0; garble_val4 = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        n_total++; if (cmd_ready1 !== 1'b1) $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready1); else n_pass++;
        n_total++; if (fifo_count1 !== 3'd0) $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count1); else n_pass++;
        n_total++; if ({alu_op1, alu_a1, alu_b1} !== 12'h000) $display("FAIL reset_alu got=%h exp=000", {alu_op1, alu_a1, alu_b1}); else n_pass++;
        n_total++; if ({rsp_valid1, rsp_err1, busy1} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {rsp_valid1, rsp_err1, busy1}); else n_pass++;
        n_total++; if ({rsp_result1, rsp_tag1} !== 6'd0) $display("FAIL reset_rsp_data got=%h exp=0", {rsp_result1, rsp_tag1}); else n_pass++;
        n_total++; if ({cmd_ready4, rsp_valid4, busy4} !== 3'b100) $display("FAIL reset_dut4 got=%b exp=100", {cmd_ready4, rsp_valid4, busy4}); else n_pass++;
    endtask

    task automatic test_single();
        rsp_ready1 = 1'b1;
        drive1(4'b1000, 4'd3, 4'd4, 2'd1);
        tick();  // accept
        cmd_valid1 = 1'b0;
        n_total++; if ({fifo_count1, rsp_valid1} !== {3'd1, 1'b0}) $display("FAIL single_accept got=%0d/%b exp=1/0", fifo_count1, rsp_valid1); else n_pass++;
        tick();  // pop
        n_total++; if ({alu_op1, alu_a1, alu_b1} !== {4'b1000, 4'd3, 4'd4}) $display("FAIL single_alu got=%h exp=834", {alu_op1, alu_a1, alu_b1}); else n_pass++;
        n_total++; if ({busy1, rsp_valid1, fifo_count1} !== {1'b1, 1'b0, 3'd0}) $display("FAIL single_issue got=%b exp=10000", {busy1, rsp_valid1, fifo_count1}); else n_pass++;
        tick();  // capture
        n_total++; if ({rsp_valid1, rsp_result1, rsp_tag1, rsp_err1} !== {1'b1, 4'd7, 2'd1, 1'b0}) $display("FAIL single_rsp got=%b/%0d/%0d/%b exp=1/7/1/0", rsp_valid1, rsp_result1, rsp_tag1, rsp_err1); else n_pass++;
        tick();  // consumed
        n_total++; if ({rsp_valid1, busy1, alu_op1} !== {1'b0, 1'b0, 4'b1000}) $display("FAIL single_idle got=%b/%b/%b exp=0/0/1000", rsp_valid1, busy1, alu_op1); else n_pass++;
    endtask

    // One command goes into flight, four more fill the FIFO, the sixth stalls.
    task automatic test_back_to_back();
        logic [5:0] got_q [$];
        logic       acc;
        rsp_ready1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (cmd_ready1 !== 1'b1) $display("FAIL b2b_ready_%0d got=%b exp=1", i, cmd_ready1); else n_pass++;
            drive1(4'b1000, 4'(i + 1), 4'd2, 2'(i));
            tick();
        end
        drive1(4'b1000, 4'd6, 4'd2, 2'd1);
        n_total++; if ({cmd_ready1, fifo_count1} !== {1'b0, 3'd4}) $display("FAIL b2b_full got=%b/%0d exp=0/4", cmd_ready1, fifo_count1); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++;
            if ({rsp_valid1, rsp_result1, rsp_tag1, rsp_err1, cmd_ready1} !== {1'b1, 4'd3, 2'd0, 1'b0, 1'b0})
                $display("FAIL b2b_hold_%0d got=%b/%0d/%0d/%b/%b exp=1/3/0/0/0", k, rsp_valid1, rsp_result1, rsp_tag1, rsp_err1, cmd_ready1);
            else n_pass++;
        end
        rsp_ready1 = 1'b1;
        for (int cyc = 0; cyc < 60 && got_q.size() < 6; cyc++) begin
            acc = cmd_valid1 && cmd_ready1;
            if (rsp_valid1) got_q.push_back({rsp_tag1, rsp_result1});
            tick();
            if (acc) cmd_valid1 = 1'b0;
        end
        n_total++; if (got_q.size() != 6) $display("FAIL b2b_count got=%0d exp=6", got_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            n_total++;
            if (got_q[i] !== {2'(i), 4'(i + 3)}) $display("FAIL b2b_order_%0d got=%h exp=%h", i, got_q[i], {2'(i), 4'(i + 3)});
            else n_pass++;
        end
        cmd_valid1 = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        rsp_ready1 = 1'b1;
        drive1(4'b1001, 4'd9, 4'd2, 2'd0);
        tick();
        drive1(4'b1110, 4'd5, 4'd5, 2'd2);
        tick();
        n_total++; if (alu_op1 !== 4'b1001) $display("FAIL ill_first_issue got=%b exp=1001", alu_op1); else n_pass++;
        drive1(4'b0011, 4'b0101, 4'b0011, 2'd3);
        tick();
        cmd_valid1 = 1'b0;
        n_total++; if ({rsp_valid1, rsp_result1, rsp_tag1, rsp_err1} !== {1'b1, 4'd7, 2'd0, 1'b0}) $display("FAIL ill_before got=%b/%0d/%0d/%b exp=1/7/0/0", rsp_valid1, rsp_result1, rsp_tag1, rsp_err1); else n_pass++;
        tick();
        n_total++; if ({rsp_valid1, rsp_result1, rsp_tag1, rsp_err1} !== {1'b1, 4'd0, 2'd2, 1'b1}) $display("FAIL ill_rsp got=%b/%0d/%0d/%b exp=1/0/2/1", rsp_valid1, rsp_result1, rsp_tag1, rsp_err1); else n_pass++;
        n_total++; if ({alu_op1, alu_a1, alu_b1} !== {4'b1001, 4'd9, 4'd2}) $display("FAIL ill_alu_hold got=%h exp=992", {alu_op1, alu_a1, alu_b1}); else n_pass++;
        tick();
        n_total++; if ({rsp_valid1, alu_op1} !== {1'b0, 4'b0011}) $display("FAIL ill_next_issue got=%b/%b exp=0/0011", rsp_valid1, alu_op1); else n_pass++;
        tick();
        n_total++; if ({rsp_valid1, rsp_result1, rsp_tag1, rsp_err1} !== {1'b1, 4'b0110, 2'd3, 1'b0}) $display("FAIL ill_after got=%b/%0d/%0d/%b exp=1/6/3/0", rsp_valid1, rsp_result1, rsp_tag1, rsp_err1); else n_pass++;
        tick();
        n_total++; if (busy1 !== 1'b0) $display("FAIL ill_idle got=%b exp=0", busy1); else n_pass++;
    endtask

    task automatic test_latency4();
        rsp_ready4  = 1'b1;
        garble4     = 1'b1;
        garble_val4 = 4'b0111;
        cmd_valid4 = 1'b1; cmd_op4 = 4'b0001; cmd_a4 = 4'b1100; cmd_b4 = 4'b1010; cmd_tag4 = 2'd1;
        tick();  // accept
        cmd_valid4 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_total++; if (rsp_valid4 !== 1'b0) $display("FAIL lat4_early_%0d got=%b exp=0", k, rsp_valid4); else n_pass++;
            if (k == 1) begin
                n_total++; if (alu_op4 !== 4'b0001) $display("FAIL lat4_alu_op got=%b exp=0001", alu_op4); else n_pass++;
            end
            if (k == 4) garble4 = 1'b0;  // true ALU value only in the final settle cycle
        end
        tick();
        n_total++; if ({rsp_valid4, rsp_result4, rsp_tag4, rsp_err4} !== {1'b1, 4'b1000, 2'd1, 1'b0}) $display("FAIL lat4_rsp got=%b/%b/%0d/%b exp=1/1000/1/0", rsp_valid4, rsp_result4, rsp_tag4, rsp_err4); else n_pass++;
        tick();
        n_total++; if ({rsp_valid4, busy4} !== 2'b00) $display("FAIL lat4_idle got=%b exp=00", {rsp_valid4, busy4}); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int stale;
        rsp_ready4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_valid4 = 1'b1; cmd_op4 = 4'b1000; cmd_a4 = 4'(i + 5); cmd_b4 = 4'd1; cmd_tag4 = 2'(i);
            tick();
        end
        cmd_valid4 = 1'b0;
        n_total++; if ({busy4, fifo_count4, alu_a4} !== {1'b1, 3'd3, 4'd5}) $display("FAIL rmid_pre got=%b/%0d/%0d exp=1/3/5", busy4, fifo_count4, alu_a4); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if ({rsp_valid4, fifo_count4, busy4} !== {1'b0, 3'd0, 1'b0}) $display("FAIL rmid_state got=%b/%0d/%b exp=0/0/0", rsp_valid4, fifo_count4, busy4); else n_pass++;
        n_total++; if ({alu_op4, alu_a4, alu_b4} !== 12'h000) $display("FAIL rmid_alu got=%h exp=000", {alu_op4, alu_a4, alu_b4}); else n_pass++;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (rsp_valid4 === 1'b1) stale++;
        end
        n_total++; if (stale != 0) $display("FAIL rmid_stale got=%0d exp=0", stale); else n_pass++;
        n_total++; if ({cmd_ready4, fifo_count4} !== {1'b1, 3'd0}) $display("FAIL rmid_after got=%b/%0d exp=1/0", cmd_ready4, fifo_count4); else n_pass++;
    endtask

    task automatic drive_stream(input int i);
        drive1(4'(i % 12), 4'((i * 3 + 1) % 16), 4'((i * 5 + 2) % 16), 2'(i % 4));
    endtask

    task automatic test_stream();
        int         sent, got, max_cnt;
        logic       acc, rv;
        logic [6:0] obs, exp;
        logic [3:0] op_i, a_i, b_i;
        sent = 0; got = 0; max_cnt = 0;
        rsp_ready1 = 1'b1;
        drive_stream(0);
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            acc = cmd_valid1 && cmd_ready1;
            rv  = rsp_valid1;
            obs = {rsp_tag1, rsp_err1, rsp_result1};
            if (int'(fifo_count1) > max_cnt) max_cnt = int'(fifo_count1);
            tick();
            if (rv) begin
                op_i = 4'(got % 12); a_i = 4'((got * 3 + 1) % 16); b_i = 4'((got * 5 + 2) % 16);
                exp  = {2'(got % 4), 1'b0, alu_f(op_i, a_i, b_i)};
                n_total++; if (obs !== exp) $display("FAIL stream_rsp_%0d got=%h exp=%h", got, obs, exp); else n_pass++;
                got++;
            end
            if (acc) begin
                sent++;
                if (sent < 20) drive_stream(sent);
                else cmd_valid1 = 1'b0;
            end
        end
        n_total++; if (got != 20 || sent != 20) $display("FAIL stream_count got=%0d/%0d exp=20/20", got, sent); else n_pass++;
        n_total++; if (max_cnt > 4) $display("FAIL stream_max_count got=%0d exp<=4", max_cnt); else n_pass++;
        tick();
        n_total++; if ({busy1, fifo_count1, rsp_valid1} !== {1'b0, 3'd0, 1'b0}) $display("FAIL stream_drained got=%b/%0d/%b exp=0/0/0", busy1, fifo_count1, rsp_valid1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_illegal();
        test_latency4();
        test_reset_mid();
        test_stream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
